// File: rtl/pulse_stretch_display_if.sv
// rtl/pulse_stretch_display_if.sv - event strobe in, stretched LED level and queue status out
interface pulse_stretch_display_if #(
  parameter int PEND_W = 2
);
  logic              in;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output in, input out, busy, pending, overflow);
  modport slave  (input in, output out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretch_display.sv
// rtl/pulse_stretch_display.sv - turns single-cycle event pulses into fixed-length LED blinks
module pulse_stretch_display #(
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int PEND_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pulse_stretch_display_if.slave  bus
);
  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              consume, dec, inc;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    consume    = 1'b0;
    dec        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in) begin
          state_d = ON;
          timer_d = ON_LOAD;
          consume = 1'b1;
        end
      end
      ON: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (pending_q != '0) begin
          // Queued events take priority; a simultaneous strobe is queued in its place.
          state_d = ON;
          timer_d = ON_LOAD;
          dec     = 1'b1;
        end else if (bus.in) begin
          state_d = ON;
          timer_d = ON_LOAD;
          consume = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    inc = bus.in && !consume;
    if (inc && !dec) begin
      if (pending_q != PEND_MAX) pending_d = pending_q + 1'b1;
      else                       overflow_d = 1'b1;
    end else if (dec && !inc) begin
      pending_d = pending_q - 1'b1;
    end

    // Outputs decode the next state so they are flop outputs aligned with the state.
    out_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_pulse_stretch_display.sv
// tb/tb_pulse_stretch_display.sv - scoreboard bench for pulse_stretch_display with directed vectors
module tb_pulse_stretch_display;
  logic clk = 1'b0;
  logic reset_n;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [4:0] exp_q[$];

  pulse_stretch_display_if #(.PEND_W(2)) bus ();

  pulse_stretch_display #(.ON_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {bus.out, bus.busy, bus.pending, bus.overflow};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got out/busy/pend/ovf=%b/%b/%0d/%b expected %b/%b/%0d/%b at %0t",
                  name, got[4], got[3], got[2:1], got[0], exp[4], exp[3], exp[2:1], exp[0], $time);
  endtask

  // One stimulus cycle: drive in for the next edge and queue the state expected after it.
  task automatic step(input int n, input logic in_v, input logic o, input logic b,
                      input logic [1:0] p, input logic v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in = in_v;
      exp_q.push_back({o, b, p, v});
    end
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cycle", obs(), e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    bus.in  = 1'b1;
    #1;
    check("reset_async", obs(), 5'b00000);
    repeat (3) begin
      @(negedge clk);
      check("reset_held", obs(), 5'b00000);
    end
    bus.in  = 1'b0;
    reset_n = 1'b1;

    // single pulse
    step(1, 1, 1, 1, 0, 0);
    step(3, 0, 1, 1, 0, 0);
    step(2, 0, 0, 1, 0, 0);
    step(2, 0, 0, 0, 0, 0);

    // three back-to-back pulses
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 2, 0);
    step(1, 0, 1, 1, 2, 0);
    step(2, 0, 0, 1, 2, 0);
    step(4, 0, 1, 1, 1, 0);
    step(2, 0, 0, 1, 1, 0);
    step(4, 0, 1, 1, 0, 0);
    step(2, 0, 0, 1, 0, 0);
    step(2, 0, 0, 0, 0, 0);

    // pulse coincides with dequeue at end of gap
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    step(2, 0, 1, 1, 1, 0);
    step(2, 0, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1, 0);
    step(3, 0, 1, 1, 1, 0);
    step(2, 0, 0, 1, 1, 0);
    step(4, 0, 1, 1, 0, 0);
    step(2, 0, 0, 1, 0, 0);
    step(2, 0, 0, 0, 0, 0);

    // five pulses: saturation and sticky overflow
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 2, 0);
    step(1, 1, 1, 1, 3, 0);
    step(1, 1, 0, 1, 3, 1);
    step(1, 0, 0, 1, 3, 1);
    step(4, 0, 1, 1, 2, 1);
    step(2, 0, 0, 1, 2, 1);
    step(4, 0, 1, 1, 1, 1);
    step(2, 0, 0, 1, 1, 1);
    step(4, 0, 1, 1, 0, 1);
    step(2, 0, 0, 1, 0, 1);
    step(2, 0, 0, 0, 0, 1);

    // build ON with timer=2, pending=2, then reset between edges
    step(1, 1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 2, 1);
    step(1, 0, 1, 1, 2, 1);
    step(2, 0, 0, 1, 2, 1);
    step(1, 1, 1, 1, 2, 1);
    step(1, 0, 1, 1, 2, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_mid_on", obs(), 5'b00000);
    @(negedge clk);
    check("reset_mid_on_held", obs(), 5'b00000);
    reset_n = 1'b1;
    step(8, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
